// File: rtl/ov7670_pkg.sv
// Shared constants and capture state encoding for the OV7670 capture path.
package ov7670_pkg;

  localparam int unsigned SRC_W_DEF = 640;
  localparam int unsigned SRC_H_DEF = 480;
  localparam int unsigned DST_PIX   = 76800;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_SKIP    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/ov7670_capture_decim.sv
// OV7670 RGB565 capture with 2:1 decimation in x and y into a linear frame buffer.
module ov7670_capture_decim
  import ov7670_pkg::*;
#(
  parameter int unsigned SRC_W  = SRC_W_DEF,
  parameter int unsigned SRC_H  = SRC_H_DEF,
  parameter int unsigned ADDR_W = $clog2(DST_PIX)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              href,
  input  logic              vsync,
  input  logic [7:0]        data,
  input  logic              freeze,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [15:0]       wData,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int unsigned XW    = $clog2(SRC_W + 1);
  localparam int unsigned YW    = $clog2(SRC_H + 1);
  localparam int unsigned DST_N = (SRC_W / 2) * (SRC_H / 2);

  localparam logic [1:0] IDLE    = 2'(ST_IDLE);
  localparam logic [1:0] SYNC    = 2'(ST_SYNC);
  localparam logic [1:0] CAPTURE = 2'(ST_CAPTURE);
  localparam logic [1:0] SKIP    = 2'(ST_SKIP);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic              href_q;
  logic              phase;
  logic [7:0]        hi_byte;
  logic [XW-1:0]     src_x;
  logic [YW-1:0]     src_y;
  logic [ADDR_W-1:0] addr_cnt;

  logic active;
  logic href_fall;
  logic in_line;
  logic byte_take;
  logic wr_ok;
  logic enter_cap;
  logic end_cap;
  logic err_set;

  // Next-state logic; freeze only matters at the end of vertical blank.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (vsync) state_nx = SYNC;
      SYNC:    if (!vsync) state_nx = freeze ? SKIP : CAPTURE;
      CAPTURE: if (vsync) state_nx = SYNC;
      SKIP:    if (vsync) state_nx = SYNC;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // A vsync rise in CAPTURE ends the frame immediately, so no byte is taken that cycle.
  always_comb begin
    active    = (state == CAPTURE) && !vsync;
    href_fall = active && href_q && !href;
    in_line   = src_x < XW'(SRC_W);
    byte_take = active && href && in_line;
    wr_ok     = byte_take && phase && !src_x[0] && !src_y[0] &&
                (src_y < YW'(SRC_H)) && (addr_cnt < ADDR_W'(DST_N));
    enter_cap = (state == SYNC) && !vsync && !freeze;
    end_cap   = (state == CAPTURE) && vsync;
    err_set   = (active && href && !in_line) ||
                (href_fall && (phase || (src_x != XW'(SRC_W)) || (src_y >= YW'(SRC_H)))) ||
                (end_cap && (href || (src_y != YW'(SRC_H))));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      href_q     <= 1'b0;
      phase      <= 1'b0;
      hi_byte    <= 8'd0;
      src_x      <= '0;
      src_y      <= '0;
      addr_cnt   <= '0;
      we         <= 1'b0;
      wAddr      <= '0;
      wData      <= 16'd0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      href_q     <= href;
      we         <= wr_ok;
      frame_done <= end_cap;
      if (err_set) frame_err <= 1'b1;

      if (wr_ok) begin
        wAddr    <= addr_cnt;
        wData    <= {hi_byte, data};
        addr_cnt <= addr_cnt + ADDR_W'(1);
      end else if (enter_cap) begin
        addr_cnt <= '0;
      end

      // Byte pairing; a dangling high byte is dropped when the line ends.
      if (!active || href_fall) begin
        phase <= 1'b0;
        src_x <= '0;
      end else if (byte_take) begin
        phase <= ~phase;
        if (!phase) hi_byte <= data;
        else        src_x   <= src_x + XW'(1);
      end

      if (enter_cap) src_y <= '0;
      else if (href_fall && (src_y < YW'(SRC_H))) src_y <= src_y + YW'(1);
    end
  end

endmodule

// File: tb/tb_ov7670_capture_decim.sv
// Directed bench for ov7670_capture_decim on a reduced 8x6 source geometry.
module tb_ov7670_capture_decim;

  localparam int W = 8;
  localparam int H = 6;
  localparam int NPIX = (W / 2) * (H / 2);

  logic        clk = 1'b0;
  logic        reset;
  logic        href;
  logic        vsync;
  logic [7:0]  data;
  logic        freeze;
  logic        we;
  logic [16:0] wAddr;
  logic [15:0] wData;
  logic        frame_done;
  logic        frame_err;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [16:0] wa [0:511];
  logic [15:0] wd [0:511];

  ov7670_capture_decim #(.SRC_W(W), .SRC_H(H)) dut (
    .clk(clk), .reset(reset), .href(href), .vsync(vsync), .data(data),
    .freeze(freeze), .we(we), .wAddr(wAddr), .wData(wData),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Write and frame_done recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (we && wr_cnt < 512) begin
      wa[wr_cnt] = wAddr;
      wd[wr_cnt] = wData;
      wr_cnt++;
    end
    if (frame_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic h, input logic [7:0] d);
    href = h;
    data = d;
    tick();
  endtask

  function automatic logic [7:0] byte_val(input int b);
    int x;
    x = b / 2;
    return (b % 2 == 0) ? 8'(x >> 8) : 8'(x);
  endfunction

  task automatic do_reset();
    reset = 1'b1; href = 1'b0; vsync = 1'b0; freeze = 1'b0; data = 8'd0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic start_frame(input logic frz);
    vsync = 1'b1; href = 1'b0; freeze = frz;
    tick(); tick(); tick();
    vsync = 1'b0;
    tick();
    freeze = 1'b0;
    tick(); tick();
  endtask

  task automatic send_line(input int nbytes);
    for (int b = 0; b < nbytes; b++) put(1'b1, byte_val(b));
    put(1'b0, 8'd0);
    put(1'b0, 8'd0);
  endtask

  task automatic run_frame(input logic frz, input int short_ln, input int long_ln, input int abort_ln);
    start_frame(frz);
    for (int ln = 0; ln < H; ln++) begin
      if (ln == abort_ln) begin
        for (int b = 0; b <= W; b++) put(1'b1, byte_val(b));
        vsync = 1'b1;
        put(1'b1, byte_val(W + 1));
        put(1'b0, 8'd0);
        tick();
        return;
      end
      if (ln == short_ln)     send_line(2 * W - 1);
      else if (ln == long_ln) send_line(2 * W + 2);
      else                    send_line(2 * W);
    end
    vsync = 1'b1;
    tick(); tick();
  endtask

  task automatic check_writes(input string tag, input int base, input int n);
    check({tag, "_count"}, 32'(wr_cnt - base), 32'(n));
    for (int k = 0; k < n && base + k < wr_cnt; k++) begin
      check({tag, "_addr"}, 32'(wa[base + k]), 32'(k));
      check({tag, "_data"}, 32'(wd[base + k]), 32'(2 * (k % (W / 2))));
    end
  endtask

  initial begin
    int base;
    int dbase;

    // Reset released mid-line with vsync low: nothing may be written.
    reset = 1'b1; vsync = 1'b0; freeze = 1'b0; href = 1'b1; data = 8'h55;
    tick(); tick();
    check("rst_we", 32'(we), 32'd0);
    check("rst_waddr", 32'(wAddr), 32'd0);
    check("rst_wdata", 32'(wData), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    base = wr_cnt;
    for (int i = 0; i < 3; i++) send_line(2 * W);
    check("partial_no_writes", 32'(wr_cnt - base), 32'd0);

    // Normal frame.
    base = wr_cnt; dbase = done_cnt;
    run_frame(1'b0, -1, -1, -1);
    check_writes("full", base, NPIX);
    check("full_done", 32'(done_cnt - dbase), 32'd1);
    check("full_err", 32'(frame_err), 32'd0);

    // Frozen frame, then a normal one.
    base = wr_cnt; dbase = done_cnt;
    run_frame(1'b1, -1, -1, -1);
    check("freeze_writes", 32'(wr_cnt - base), 32'd0);
    check("freeze_done", 32'(done_cnt - dbase), 32'd0);
    base = wr_cnt; dbase = done_cnt;
    run_frame(1'b0, -1, -1, -1);
    check_writes("after_freeze", base, NPIX);
    check("after_freeze_done", 32'(done_cnt - dbase), 32'd1);

    // Single pixel latency and value.
    do_reset();
    start_frame(1'b0);
    put(1'b1, 8'hF8);
    put(1'b1, 8'h1F);
    check("pix_we", 32'(we), 32'd1);
    check("pix_waddr", 32'(wAddr), 32'd0);
    check("pix_wdata", 32'(wData), 32'hF81F);
    put(1'b1, 8'h00);
    check("pix_we_pulse", 32'(we), 32'd0);

    // Reset on the completing byte suppresses the write.
    do_reset();
    start_frame(1'b0);
    base = wr_cnt;
    put(1'b1, 8'hF8);
    reset = 1'b1;
    put(1'b1, 8'h1F);
    check("rst_mid_we", 32'(we), 32'd0);
    reset = 1'b0;
    put(1'b0, 8'd0);
    tick();
    check("rst_mid_writes", 32'(wr_cnt - base), 32'd0);

    // Odd-length line.
    do_reset();
    check("short_err_pre", 32'(frame_err), 32'd0);
    base = wr_cnt;
    run_frame(1'b0, 2, -1, -1);
    check_writes("short", base, NPIX);
    check("short_err", 32'(frame_err), 32'd1);

    // Over-long line.
    do_reset();
    base = wr_cnt;
    run_frame(1'b0, -1, 0, -1);
    check_writes("long", base, NPIX);
    check("long_err", 32'(frame_err), 32'd1);

    // vsync rising mid-line, then recovery.
    do_reset();
    base = wr_cnt; dbase = done_cnt;
    run_frame(1'b0, -1, -1, 2);
    check_writes("abort", base, W / 2 + 2);
    check("abort_done", 32'(done_cnt - dbase), 32'd1);
    check("abort_err", 32'(frame_err), 32'd1);
    base = wr_cnt; dbase = done_cnt;
    run_frame(1'b0, -1, -1, -1);
    check_writes("recover", base, NPIX);
    check("recover_done", 32'(done_cnt - dbase), 32'd1);
    check("recover_err_sticky", 32'(frame_err), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ov7670_capture_decim.md
OV7670_CAPTURE_DECIM -- requirements
Module: ov7670_capture_decim

Interface
REQ-001 SHALL have parameter SRC_W, default 640, camera pixels per line.
REQ-002 SHALL have parameter SRC_H, default 480, camera lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 17, frame-buffer address width.
REQ-004 clk  input  1  camera pixel clock; single clock, all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 href  input  1  camera line-valid.
REQ-007 vsync  input  1  camera vertical sync; high = vertical blank.
REQ-008 data  input  8  camera byte, RGB565, high byte first.
REQ-009 freeze  input  1  skip capture of next frame, leaving buffer unchanged.
REQ-010 we  output  1  frame-buffer write enable.
REQ-011 wAddr  output  ADDR_W  frame-buffer write address, dst_y*(SRC_W/2)+dst_x.
REQ-012 wData  output  16  RGB565 pixel.
REQ-013 frame_done  output  1  one-cycle pulse at end of a captured frame.
REQ-014 frame_err  output  1  sticky; set when a captured frame's line count != SRC_H or a line's byte count != 2*SRC_W.

Function
REQ-015 States: IDLE, SYNC, CAPTURE, SKIP.
REQ-016 IDLE -> SYNC when vsync=1, so a partial frame after reset is never written.
REQ-017 SYNC -> CAPTURE on vsync=0 with freeze=0; SYNC -> SKIP on vsync=0 with freeze=1; freeze sampled only at this transition.
REQ-018 CAPTURE -> SYNC on vsync=1, pulsing frame_done the same cycle the state changes; SKIP -> SYNC on vsync=1 with no pulse.
REQ-019 In CAPTURE, byte phase toggles on each href=1 cycle: phase 0 latches data as high byte, phase 1 completes pixel {high, data}.
REQ-020 Source x counter increments per completed pixel; clears and byte phase clears on href falling edge.
REQ-021 Source y counter increments on each href falling edge in CAPTURE; clears on entry to CAPTURE.
REQ-022 Pixel SHALL be written only when src_x and src_y both even, src_x<SRC_W, src_y<SRC_H (2:1 decimation to SRC_W/2 x SRC_H/2).
REQ-023 we, wData, wAddr registered: asserted exactly one cycle after the phase-1 byte is sampled, we high for one cycle per pixel.
REQ-024 wAddr generated by incrementing counter (no multiplier), 0 at CAPTURE entry, +1 per write, max (SRC_W/2)*(SRC_H/2)-1 = 76799; writes beyond are suppressed.
REQ-025 Odd byte count at href fall: dangling high byte discarded, frame_err set.
REQ-026 Bytes beyond 2*SRC_W in a line ignored, frame_err set.
REQ-027 vsync=1 mid-line (href=1) in CAPTURE: line aborted, no further writes, frame_done still pulses, frame_err set.
REQ-028 frame_err cleared only by reset.
REQ-029 In IDLE, SYNC, SKIP: we=0 always.

Reset
REQ-030 On reset: state IDLE; we=0, wAddr=0, wData=0, frame_done=0, frame_err=0; all counters and byte phase 0.
REQ-031 Reset asserted mid-line SHALL suppress the pending write in the following cycle.

Structure
REQ-032 Shared package ov7670_pkg SHALL hold SRC_W/SRC_H defaults, DST pixel count 76800, and the capture state enum.
REQ-033 Single module; no sub-module (pairing, decimation and address counters are inline).

Verification
REQ-034 Reset, then vsync 1->0, 480 lines of 1280 bytes with pixel value = src_x -> 76800 writes, wAddr 0..76799 contiguous, first wData=0x0000, second wData=0x0002, frame_done once, frame_err=0.
REQ-035 Reset released while vsync=0 and href active -> no writes until vsync has gone high then low.
REQ-036 freeze=1 at vsync fall -> zero writes that frame, no frame_done; freeze=0 next frame -> full 76800 writes.
REQ-037 One line of 1279 bytes -> that line's last pixel not written, frame_err=1, later lines address-correct.
REQ-038 vsync rises during line 100 -> writes stop immediately, frame_done pulses, frame_err=1; next frame restarts at wAddr=0.
REQ-039 Single pixel bytes 0xF8,0x1F at src (0,0) -> one cycle later we=1, wAddr=0, wData=0xF81F.
